// File: rtl/vector_ave_multi_if.sv
// Sample/result bus for vector_ave_multi: packed multi-lane samples in,
// per-frame averages out. The design takes the slave view.
interface vector_ave_multi_if #(
  parameter int LANES = 4,
  parameter int DW    = 16,
  parameter int FW    = 16
);
  logic                    op_din_en;
  logic                    op_din_eop;
  logic [LANES*DW-1:0]     op_din;
  logic signed [FW-1:0]    fraction;
  logic [LANES*DW-1:0]     op_dout;
  logic                    op_dout_vld;
  logic [15:0]             frame_cnt;

  modport master (
    output op_din_en, op_din_eop, op_din, fraction,
    input  op_dout, op_dout_vld, frame_cnt
  );

  modport slave (
    input  op_din_en, op_din_eop, op_din, fraction,
    output op_dout, op_dout_vld, frame_cnt
  );
endinterface

// File: rtl/vector_ave_multi.sv
// Multi-lane frame averager: per-lane sum of (sample * fraction), scaled by >>>Q.
// Define VECTOR_AVE_SAT_EN to clamp results to DW bits instead of wrapping.
module vector_ave_multi #(
  parameter int LANES = 4,
  parameter int DW    = 16,
  parameter int FW    = 16,
  parameter int Q     = 8,
  parameter int GUARD = 8,
  parameter int RELU  = 0
) (
  input  logic               clk,
  input  logic               rst,
  vector_ave_multi_if.slave  bus
);

  localparam int PW   = DW + FW;
  localparam int ACCW = PW + GUARD;

  function automatic logic signed [PW-1:0] lane_mult(
    input logic signed [DW-1:0] a,
    input logic signed [FW-1:0] f
  );
    logic signed [PW-1:0] ax;
    logic signed [PW-1:0] fx;
    ax = {{FW{a[DW-1]}}, a};
    fx = {{DW{f[FW-1]}}, f};
    return ax * fx;
  endfunction

`ifdef VECTOR_AVE_SAT_EN
  localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  function automatic logic signed [DW-1:0] scale_reduce(input logic signed [ACCW-1:0] a);
    logic signed [ACCW-1:0] s;
    s = a >>> Q;
    if (s > SAT_MAX)      return SAT_MAX[DW-1:0];
    else if (s < SAT_MIN) return SAT_MIN[DW-1:0];
    else                  return s[DW-1:0];
  endfunction
`else
  // Without saturation the shift-then-truncate is just a bit slice (wraps).
  function automatic logic signed [DW-1:0] scale_reduce(input logic signed [ACCW-1:0] a);
    return a[Q+DW-1:Q];
  endfunction
`endif

  function automatic logic signed [DW-1:0] relu_clamp(input logic signed [DW-1:0] v);
    if ((RELU != 0) && v[DW-1]) return '0;
    else                        return v;
  endfunction

  // ---- stage 1: lane products with beat/eop tags ----
  logic                  vld_p1;
  logic                  eop_p1;
  logic signed [PW-1:0]  prod_p1 [LANES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      eop_p1 <= 1'b0;
    end else begin
      vld_p1 <= bus.op_din_en;
      eop_p1 <= bus.op_din_en & bus.op_din_eop;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.op_din_en) begin
      for (int i = 0; i < LANES; i++)
        prod_p1[i] <= lane_mult(bus.op_din[i*DW +: DW], bus.fraction);
    end
  end

  // ---- stage 2: per-lane accumulation, restarted by the first flag ----
  logic                    first_p2;
  logic                    done_p2;
  logic signed [ACCW-1:0]  acc_p2 [LANES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_p2 <= 1'b1;
      done_p2  <= 1'b0;
      for (int i = 0; i < LANES; i++)
        acc_p2[i] <= '0;
    end else begin
      done_p2 <= vld_p1 & eop_p1;
      if (vld_p1) begin
        first_p2 <= eop_p1;
        for (int i = 0; i < LANES; i++)
          acc_p2[i] <= (first_p2 ? '0 : acc_p2[i]) + {{GUARD{prod_p1[i][PW-1]}}, prod_p1[i]};
      end
    end
  end

  // ---- stage 3: scale, reduce and publish the finished frame ----
  // acc_p2 is read before any new-frame beat overwrites it on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.op_dout     <= '0;
      bus.op_dout_vld <= 1'b0;
      bus.frame_cnt   <= '0;
    end else begin
      bus.op_dout_vld <= done_p2;
      if (done_p2) begin
        for (int i = 0; i < LANES; i++)
          bus.op_dout[i*DW +: DW] <= relu_clamp(scale_reduce(acc_p2[i]));
        bus.frame_cnt <= bus.frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_vector_ave_multi.sv
// Directed bench for vector_ave_multi: a RELU=0 and a RELU=1 instance share stimulus.
module tb_vector_ave_multi;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vector_ave_multi_if #(.LANES(4), .DW(16), .FW(16)) bus0 ();
  vector_ave_multi_if #(.LANES(4), .DW(16), .FW(16)) bus1 ();

  vector_ave_multi #(.LANES(4), .DW(16), .FW(16), .Q(8), .GUARD(8), .RELU(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave));
  vector_ave_multi #(.LANES(4), .DW(16), .FW(16), .Q(8), .GUARD(8), .RELU(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave));

  typedef struct {
    int          cyc;
    logic [63:0] dout;
    logic [15:0] cnt;
  } rec_t;

  rec_t q0[$];
  rec_t q1[$];

  always @(negedge clk) begin
    if (bus0.op_dout_vld) q0.push_back('{cyc, bus0.op_dout, bus0.frame_cnt});
    if (bus1.op_dout_vld) q1.push_back('{cyc, bus1.op_dout, bus1.frame_cnt});
  end

  function automatic logic signed [15:0] lane(input logic [63:0] d, input int i);
    return d[i*16 +: 16];
  endfunction

  task automatic beat(input logic en, input logic eop,
                      input logic signed [15:0] l0, input logic signed [15:0] l1,
                      input logic signed [15:0] l2, input logic signed [15:0] l3,
                      input logic signed [15:0] fr);
    bus0.op_din_en  = en;  bus1.op_din_en  = en;
    bus0.op_din_eop = eop; bus1.op_din_eop = eop;
    bus0.op_din     = {l3, l2, l1, l0};
    bus1.op_din     = {l3, l2, l1, l0};
    bus0.fraction   = fr;  bus1.fraction   = fr;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) beat(1'b0, 1'b0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    checks++;
    if (bus0.op_dout_vld !== 1'b0) begin failures++; $display("FAIL reset_vld got=%b want=0", bus0.op_dout_vld); end
    checks++;
    if (bus0.op_dout !== 64'd0) begin failures++; $display("FAIL reset_dout got=%h want=0", bus0.op_dout); end
    checks++;
    if (bus0.frame_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d want=0", bus0.frame_cnt); end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_average();
    int s;
    q0.delete();
    s = cyc;
    beat(1, 0, 16'sd256,  0, 0, 0, 16'sd64);
    beat(1, 0, 16'sd512,  0, 0, 0, 16'sd64);
    beat(1, 0, 16'sd768,  0, 0, 0, 16'sd64);
    beat(1, 1, 16'sd1024, 0, 0, 0, 16'sd64);
    idle(6);
    checks++;
    if (q0.size() !== 1) begin failures++; $display("FAIL avg_pulses got=%0d want=1", q0.size()); end
    if (q0.size() > 0) begin
      checks++;
      if (q0[0].cyc !== s + 6) begin failures++; $display("FAIL avg_latency got=%0d want=%0d", q0[0].cyc - s, 6); end
      checks++;
      if (lane(q0[0].dout, 0) !== 16'sd640) begin failures++; $display("FAIL avg_lane0 got=%0d want=640", lane(q0[0].dout, 0)); end
      checks++;
      if (lane(q0[0].dout, 1) !== 16'sd0) begin failures++; $display("FAIL avg_lane1 got=%0d want=0", lane(q0[0].dout, 1)); end
      checks++;
      if (q0[0].cnt !== 16'd1) begin failures++; $display("FAIL avg_cnt got=%0d want=1", q0[0].cnt); end
    end
  endtask

  task automatic test_gap();
    int s;
    q0.delete();
    s = cyc;
    beat(1, 0, 16'sd256, 0, 0, 0, 16'sd64);
    beat(1, 0, 16'sd512, 0, 0, 0, 16'sd64);
    // eop without en must not close the frame
    beat(0, 1, 16'sd999, 0, 0, 0, 16'sd64);
    beat(0, 0, 16'sd999, 0, 0, 0, 16'sd64);
    beat(1, 0, 16'sd768,  0, 0, 0, 16'sd64);
    beat(1, 1, 16'sd1024, 0, 0, 0, 16'sd64);
    idle(6);
    checks++;
    if (q0.size() !== 1) begin failures++; $display("FAIL gap_pulses got=%0d want=1", q0.size()); end
    if (q0.size() > 0) begin
      checks++;
      if (q0[0].cyc !== s + 8) begin failures++; $display("FAIL gap_latency got=%0d want=%0d", q0[0].cyc - s, 8); end
      checks++;
      if (lane(q0[0].dout, 0) !== 16'sd640) begin failures++; $display("FAIL gap_lane0 got=%0d want=640", lane(q0[0].dout, 0)); end
      checks++;
      if (q0[0].cnt !== 16'd2) begin failures++; $display("FAIL gap_cnt got=%0d want=2", q0[0].cnt); end
    end
  endtask

  task automatic test_back_to_back();
    int s;
    q0.delete();
    s = cyc;
    beat(1, 0, 0, 16'sd100,  0, 0, 16'sd128);
    beat(1, 1, 0, 16'sd100,  0, 0, 16'sd128);
    beat(1, 0, 0, -16'sd200, 0, 0, 16'sd128);
    beat(1, 1, 0, -16'sd200, 0, 0, 16'sd128);
    idle(6);
    checks++;
    if (q0.size() !== 2) begin failures++; $display("FAIL b2b_pulses got=%0d want=2", q0.size()); end
    if (q0.size() > 1) begin
      checks++;
      if (lane(q0[0].dout, 1) !== 16'sd100) begin failures++; $display("FAIL b2b_first got=%0d want=100", lane(q0[0].dout, 1)); end
      checks++;
      if (lane(q0[1].dout, 1) !== -16'sd200) begin failures++; $display("FAIL b2b_second got=%0d want=-200", lane(q0[1].dout, 1)); end
      checks++;
      if ((q0[0].cyc !== s + 4) || (q0[1].cyc !== s + 6)) begin
        failures++; $display("FAIL b2b_timing got=%0d,%0d want=4,6", q0[0].cyc - s, q0[1].cyc - s);
      end
      checks++;
      if (q0[1].cnt !== 16'd4) begin failures++; $display("FAIL b2b_cnt got=%0d want=4", q0[1].cnt); end
    end
  endtask

  task automatic test_saturation();
    logic signed [15:0] want;
`ifdef VECTOR_AVE_SAT_EN
    want = 16'sd32767;
`else
    want = -16'sd256;
`endif
    q0.delete();
    beat(1, 1, 0, 0, 16'sd32767, 0, 16'sd32767);
    idle(6);
    checks++;
    if (q0.size() !== 1) begin failures++; $display("FAIL sat_pulses got=%0d want=1", q0.size()); end
    if (q0.size() > 0) begin
      checks++;
      if (lane(q0[0].dout, 2) !== want) begin failures++; $display("FAIL sat_lane2 got=%0d want=%0d", lane(q0[0].dout, 2), want); end
    end
  endtask

  task automatic test_relu();
    q0.delete();
    q1.delete();
    beat(1, 0, 16'sd20, 0, 0, -16'sd30, 16'sd256);
    beat(1, 1, 16'sd10, 0, 0, -16'sd20, 16'sd256);
    idle(6);
    checks++;
    if ((q0.size() !== 1) || (q1.size() !== 1)) begin
      failures++; $display("FAIL relu_pulses got=%0d,%0d want=1,1", q0.size(), q1.size());
    end
    if ((q0.size() > 0) && (q1.size() > 0)) begin
      checks++;
      if (lane(q1[0].dout, 3) !== 16'sd0) begin failures++; $display("FAIL relu_lane3 got=%0d want=0", lane(q1[0].dout, 3)); end
      checks++;
      if (lane(q1[0].dout, 0) !== 16'sd30) begin failures++; $display("FAIL relu_lane0 got=%0d want=30", lane(q1[0].dout, 0)); end
      checks++;
      if (lane(q0[0].dout, 3) !== -16'sd50) begin failures++; $display("FAIL norelu_lane3 got=%0d want=-50", lane(q0[0].dout, 3)); end
      checks++;
      if (q0[0].cnt !== 16'd6) begin failures++; $display("FAIL relu_cnt got=%0d want=6", q0[0].cnt); end
    end
  endtask

  task automatic test_reset_midframe();
    int s;
    q0.delete();
    beat(1, 0, 16'sd1000, 0, 0, 0, 16'sd256);
    beat(1, 0, 16'sd1000, 0, 0, 0, 16'sd256);
    rst = 1'b1;
    #1;
    checks++;
    if ((bus0.frame_cnt !== 16'd0) || (bus0.op_dout !== 64'd0)) begin
      failures++; $display("FAIL async_clear got=%0d/%h want=0/0", bus0.frame_cnt, bus0.op_dout);
    end
    @(negedge clk);
    rst = 1'b0;
    s = cyc;
    beat(1, 1, 16'sd256, 0, 0, 0, 16'sd256);
    idle(6);
    checks++;
    if (q0.size() !== 1) begin failures++; $display("FAIL rstmid_pulses got=%0d want=1", q0.size()); end
    if (q0.size() > 0) begin
      checks++;
      if (q0[0].cyc !== s + 3) begin failures++; $display("FAIL rstmid_latency got=%0d want=3", q0[0].cyc - s); end
      checks++;
      if (lane(q0[0].dout, 0) !== 16'sd256) begin failures++; $display("FAIL rstmid_lane0 got=%0d want=256", lane(q0[0].dout, 0)); end
      checks++;
      if (q0[0].cnt !== 16'd1) begin failures++; $display("FAIL rstmid_cnt got=%0d want=1", q0[0].cnt); end
    end
    checks++;
    if ((lane(bus0.op_dout, 0) !== 16'sd256) || (bus0.op_dout_vld !== 1'b0)) begin
      failures++; $display("FAIL hold got=%0d vld=%b want=256 vld=0", lane(bus0.op_dout, 0), bus0.op_dout_vld);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus0.op_din_en = 1'b0; bus0.op_din_eop = 1'b0; bus0.op_din = '0; bus0.fraction = '0;
    bus1.op_din_en = 1'b0; bus1.op_din_eop = 1'b0; bus1.op_din = '0; bus1.fraction = '0;
    @(negedge clk);
    test_reset();
    test_average();
    test_gap();
    test_back_to_back();
    test_saturation();
    test_relu();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
